// File: rtl/rob_pkg.sv
// Shared sizing and entry layout for the reorder buffer.
package rob_pkg;

    localparam int ROB_SIZE = 32;
    localparam int PR_W     = 7;
    localparam int AR_W     = 5;
    localparam int IDX_W    = $clog2(ROB_SIZE);
    localparam int CNT_W    = IDX_W + 1;

    typedef struct packed {
        logic            valid;
        logic            done;
        logic            mispredict;
        logic [AR_W-1:0] dest_ar;
        logic [PR_W-1:0] new_pr;
        logic [PR_W-1:0] old_pr;
    } rob_entry_t;

    typedef enum logic [1:0] {
        RET_NONE = 2'd0,
        RET_ONE  = 2'd1,
        RET_TWO  = 2'd2
    } retire_num_e;

endpackage

// File: rtl/rob.sv
// Reorder buffer: records dispatched mappings, collects CDB completions and
// retires up to two instructions per cycle in program order.
module rob
    import rob_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       id_dispatch_num,
    input  logic [AR_W-1:0]  id_dest_ar0,
    input  logic [AR_W-1:0]  id_dest_ar1,
    input  logic [PR_W-1:0]  fl_pr0,
    input  logic [PR_W-1:0]  fl_pr1,
    input  logic [PR_W-1:0]  mt_old_pr0,
    input  logic [PR_W-1:0]  mt_old_pr1,
    input  logic             cdb_valid0,
    input  logic             cdb_valid1,
    input  logic [IDX_W-1:0] cdb_rob_idx0,
    input  logic [IDX_W-1:0] cdb_rob_idx1,
    input  logic             cdb_mispredict0,
    input  logic             cdb_mispredict1,
    output logic [IDX_W-1:0] rob_idx0,
    output logic [IDX_W-1:0] rob_idx1,
    output logic             rob_stall,
    output logic [1:0]       rob_retire_num,
    output logic [PR_W-1:0]  rob_retire_tag_0,
    output logic [PR_W-1:0]  rob_retire_tag_1,
    output logic [AR_W-1:0]  rob_retire_ar0,
    output logic [AR_W-1:0]  rob_retire_ar1,
    output logic [PR_W-1:0]  rob_retire_pr0,
    output logic [PR_W-1:0]  rob_retire_pr1,
    output logic             rob_flush
);

    rob_entry_t       entries [ROB_SIZE];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [IDX_W-1:0] head_nx1;
    logic [IDX_W-1:0] tail_nx1;
    rob_entry_t       head_e;
    rob_entry_t       next_e;
    logic             retire0;
    logic             retire1;
    logic             flush;
    logic [CNT_W-1:0] free_cnt;
    logic             disp_ok;
    logic [1:0]       disp_acc;
    retire_num_e      ret_num;

    function automatic rob_entry_t new_entry(
        input logic [AR_W-1:0] ar,
        input logic [PR_W-1:0] npr,
        input logic [PR_W-1:0] opr
    );
        rob_entry_t e;
        e.valid      = 1'b1;
        e.done       = 1'b0;
        e.mispredict = 1'b0;
        e.dest_ar    = ar;
        e.new_pr     = npr;
        e.old_pr     = opr;
        return e;
    endfunction

    // Retire decision is purely from registered state; a CDB write lands at
    // the edge, so a completion can never retire in its own cycle.
    always_comb begin
        head_nx1 = head + IDX_W'(1);
        tail_nx1 = tail + IDX_W'(1);
        head_e   = entries[head];
        next_e   = entries[head_nx1];
        retire0  = head_e.valid & head_e.done;
        flush    = retire0 & head_e.mispredict;
        retire1  = retire0 & ~head_e.mispredict & next_e.valid & next_e.done;
        if (retire1) begin
            ret_num = RET_TWO;
        end else if (retire0) begin
            ret_num = RET_ONE;
        end else begin
            ret_num = RET_NONE;
        end
    end

    // Oversized dispatch requests are dropped whole rather than partially written.
    always_comb begin
        free_cnt = CNT_W'(ROB_SIZE) - count;
        disp_ok  = (id_dispatch_num <= 2'd2) && (CNT_W'(id_dispatch_num) <= free_cnt);
        disp_acc = disp_ok ? id_dispatch_num : 2'd0;
    end

    always_comb begin
        rob_idx0         = tail;
        rob_idx1         = tail_nx1;
        rob_stall        = (count > CNT_W'(ROB_SIZE - 2));
        rob_retire_num   = ret_num;
        rob_flush        = flush;
        rob_retire_tag_0 = retire0 ? head_e.old_pr  : '0;
        rob_retire_ar0   = retire0 ? head_e.dest_ar : '0;
        rob_retire_pr0   = retire0 ? head_e.new_pr  : '0;
        rob_retire_tag_1 = retire1 ? next_e.old_pr  : '0;
        rob_retire_ar1   = retire1 ? next_e.dest_ar : '0;
        rob_retire_pr1   = retire1 ? next_e.new_pr  : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            // Everything younger than the mispredicted branch is squashed,
            // including anything dispatched or completed this cycle.
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i].valid      <= 1'b0;
                entries[i].done       <= 1'b0;
                entries[i].mispredict <= 1'b0;
            end
        end else begin
            if (cdb_valid0 && entries[cdb_rob_idx0].valid) begin
                entries[cdb_rob_idx0].done       <= 1'b1;
                entries[cdb_rob_idx0].mispredict <= cdb_mispredict0;
            end
            if (cdb_valid1 && entries[cdb_rob_idx1].valid) begin
                entries[cdb_rob_idx1].done       <= 1'b1;
                entries[cdb_rob_idx1].mispredict <= cdb_mispredict1;
            end
            if (retire0) begin
                entries[head].valid      <= 1'b0;
                entries[head].done       <= 1'b0;
                entries[head].mispredict <= 1'b0;
            end
            if (retire1) begin
                entries[head_nx1].valid      <= 1'b0;
                entries[head_nx1].done       <= 1'b0;
                entries[head_nx1].mispredict <= 1'b0;
            end
            if (disp_acc != 2'd0) begin
                entries[tail] <= new_entry(id_dest_ar0, fl_pr0, mt_old_pr0);
            end
            if (disp_acc == 2'd2) begin
                entries[tail_nx1] <= new_entry(id_dest_ar1, fl_pr1, mt_old_pr1);
            end
            head  <= head + IDX_W'(ret_num);
            tail  <= tail + IDX_W'(disp_acc);
            count <= count + CNT_W'(disp_acc) - CNT_W'(ret_num);
        end
    end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob with a queue-based program-order model.
module tb_rob;
    import rob_pkg::*;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [1:0]       id_dispatch_num;
    logic [AR_W-1:0]  id_dest_ar0, id_dest_ar1;
    logic [PR_W-1:0]  fl_pr0, fl_pr1, mt_old_pr0, mt_old_pr1;
    logic             cdb_valid0, cdb_valid1;
    logic [IDX_W-1:0] cdb_rob_idx0, cdb_rob_idx1;
    logic             cdb_mispredict0, cdb_mispredict1;
    logic [IDX_W-1:0] rob_idx0, rob_idx1;
    logic             rob_stall;
    logic [1:0]       rob_retire_num;
    logic [PR_W-1:0]  rob_retire_tag_0, rob_retire_tag_1;
    logic [AR_W-1:0]  rob_retire_ar0, rob_retire_ar1;
    logic [PR_W-1:0]  rob_retire_pr0, rob_retire_pr1;
    logic             rob_flush;

    rob dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .id_dispatch_num  (id_dispatch_num),
        .id_dest_ar0      (id_dest_ar0),
        .id_dest_ar1      (id_dest_ar1),
        .fl_pr0           (fl_pr0),
        .fl_pr1           (fl_pr1),
        .mt_old_pr0       (mt_old_pr0),
        .mt_old_pr1       (mt_old_pr1),
        .cdb_valid0       (cdb_valid0),
        .cdb_valid1       (cdb_valid1),
        .cdb_rob_idx0     (cdb_rob_idx0),
        .cdb_rob_idx1     (cdb_rob_idx1),
        .cdb_mispredict0  (cdb_mispredict0),
        .cdb_mispredict1  (cdb_mispredict1),
        .rob_idx0         (rob_idx0),
        .rob_idx1         (rob_idx1),
        .rob_stall        (rob_stall),
        .rob_retire_num   (rob_retire_num),
        .rob_retire_tag_0 (rob_retire_tag_0),
        .rob_retire_tag_1 (rob_retire_tag_1),
        .rob_retire_ar0   (rob_retire_ar0),
        .rob_retire_ar1   (rob_retire_ar1),
        .rob_retire_pr0   (rob_retire_pr0),
        .rob_retire_pr1   (rob_retire_pr1),
        .rob_flush        (rob_flush)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int seq    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Model: the in-flight instructions in program order.
    typedef struct {
        int              idx;
        logic [AR_W-1:0] ar;
        logic [PR_W-1:0] npr;
        logic [PR_W-1:0] opr;
        bit              done;
        bit              mis;
    } ment_t;

    ment_t mq[$];
    int    mtail = 0;
    int    u_n, u_sz;
    int    c_n, c_fl;

    function automatic int m_num();
        if (mq.size() == 0 || !mq[0].done) return 0;
        if (mq[0].mis) return 1;
        if (mq.size() > 1 && mq[1].done) return 2;
        return 1;
    endfunction

    function automatic void m_complete(input int idx, input bit m);
        ment_t e;
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].idx == idx) begin
                e = mq[k];
                e.done = 1'b1;
                e.mis = m;
                mq[k] = e;
            end
        end
    endfunction

    function automatic void m_push(input logic [AR_W-1:0] ar, input logic [PR_W-1:0] npr,
                                   input logic [PR_W-1:0] opr);
        ment_t e;
        e.idx = mtail; e.ar = ar; e.npr = npr; e.opr = opr; e.done = 1'b0; e.mis = 1'b0;
        mq.push_back(e);
        mtail = (mtail + 1) % ROB_SIZE;
    endfunction

    always @(negedge reset_n) begin
        mq.delete();
        mtail = 0;
    end

    always @(posedge clock) begin
        if (!reset_n) begin
            mq.delete();
            mtail = 0;
        end else begin
            u_n  = m_num();
            u_sz = mq.size();
            if (u_n == 1 && mq[0].mis) begin
                mq.delete();
                mtail = 0;
            end else begin
                if (cdb_valid0) m_complete(int'(cdb_rob_idx0), cdb_mispredict0);
                if (cdb_valid1) m_complete(int'(cdb_rob_idx1), cdb_mispredict1);
                for (int k = 0; k < u_n; k++) mq.delete(0);
                if (int'(id_dispatch_num) <= 2 && int'(id_dispatch_num) <= ROB_SIZE - u_sz) begin
                    if (id_dispatch_num >= 2'd1) m_push(id_dest_ar0, fl_pr0, mt_old_pr0);
                    if (id_dispatch_num == 2'd2) m_push(id_dest_ar1, fl_pr1, mt_old_pr1);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            c_n  = m_num();
            c_fl = (c_n == 1 && mq[0].mis) ? 1 : 0;
            chk("cmp_retire_num", int'(rob_retire_num), c_n);
            chk("cmp_flush", int'(rob_flush), c_fl);
            chk("cmp_tag0", int'(rob_retire_tag_0), c_n >= 1 ? int'(mq[0].opr) : 0);
            chk("cmp_ar0",  int'(rob_retire_ar0),   c_n >= 1 ? int'(mq[0].ar)  : 0);
            chk("cmp_pr0",  int'(rob_retire_pr0),   c_n >= 1 ? int'(mq[0].npr) : 0);
            chk("cmp_tag1", int'(rob_retire_tag_1), c_n == 2 ? int'(mq[1].opr) : 0);
            chk("cmp_ar1",  int'(rob_retire_ar1),   c_n == 2 ? int'(mq[1].ar)  : 0);
            chk("cmp_pr1",  int'(rob_retire_pr1),   c_n == 2 ? int'(mq[1].npr) : 0);
            chk("cmp_idx0", int'(rob_idx0), mtail);
            chk("cmp_idx1", int'(rob_idx1), (mtail + 1) % ROB_SIZE);
            chk("cmp_stall", int'(rob_stall), mq.size() > ROB_SIZE - 2 ? 1 : 0);
        end
    end

    task automatic clear_inputs();
        id_dispatch_num = 2'd0;
        cdb_valid0 = 1'b0; cdb_valid1 = 1'b0;
        cdb_mispredict0 = 1'b0; cdb_mispredict1 = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic disp(input int n);
        id_dispatch_num = 2'(n);
        id_dest_ar0 = AR_W'(seq);     fl_pr0 = PR_W'(seq + 50);     mt_old_pr0 = PR_W'(seq + 10);
        id_dest_ar1 = AR_W'(seq + 1); fl_pr1 = PR_W'(seq + 51);     mt_old_pr1 = PR_W'(seq + 11);
        seq += n;
    endtask

    task automatic c0(input int idx, input bit m);
        cdb_valid0 = 1'b1; cdb_rob_idx0 = IDX_W'(idx); cdb_mispredict0 = m;
    endtask

    task automatic c1(input int idx, input bit m);
        cdb_valid1 = 1'b1; cdb_rob_idx1 = IDX_W'(idx); cdb_mispredict1 = m;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        id_dest_ar0 = '0; id_dest_ar1 = '0; fl_pr0 = '0; fl_pr1 = '0;
        mt_old_pr0 = '0; mt_old_pr1 = '0; cdb_rob_idx0 = '0; cdb_rob_idx1 = '0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        chk("rst_idx0", int'(rob_idx0), 0);
        chk("rst_idx1", int'(rob_idx1), 1);
        chk("rst_stall", int'(rob_stall), 0);
        chk("rst_retire_num", int'(rob_retire_num), 0);
        chk("rst_flush", int'(rob_flush), 0);
        chk_en = 1'b1;

        // Out-of-order completion
        disp(2); tick();
        disp(2); tick();
        c0(3, 0); tick(); chk("ooo_c3", int'(rob_retire_num), 0);
        c0(2, 0); tick(); chk("ooo_c2", int'(rob_retire_num), 0);
        c0(1, 0); tick(); chk("ooo_c1", int'(rob_retire_num), 0);
        c0(0, 0); tick();
        chk("ooo_num_a", int'(rob_retire_num), 2);
        chk("ooo_tag0_a", int'(rob_retire_tag_0), 10);
        chk("ooo_tag1_a", int'(rob_retire_tag_1), 11);
        tick();
        chk("ooo_num_b", int'(rob_retire_num), 2);
        chk("ooo_tag0_b", int'(rob_retire_tag_0), 12);
        chk("ooo_tag1_b", int'(rob_retire_tag_1), 13);
        tick();
        chk("ooo_num_c", int'(rob_retire_num), 0);

        // Walk head/tail from 4 up to 30, then wrap
        for (int it = 0; it < 13; it++) begin
            disp(2); tick();
            c0(4 + 2 * it, 0); c1(5 + 2 * it, 0); tick();
        end
        tick();
        chk("wrap_idx0_30", int'(rob_idx0), 30);
        chk("wrap_idx1_31", int'(rob_idx1), 31);
        disp(2); tick();
        chk("wrap_idx0_0", int'(rob_idx0), 0);
        chk("wrap_idx1_1", int'(rob_idx1), 1);
        disp(2); tick();
        c0(30, 0); c1(31, 0); tick();
        c0(0, 0); c1(1, 0);
        chk("wrap_num_a", int'(rob_retire_num), 2);
        chk("wrap_tag0_a", int'(rob_retire_tag_0), 40);
        chk("wrap_tag1_a", int'(rob_retire_tag_1), 41);
        tick();
        chk("wrap_tag0_b", int'(rob_retire_tag_0), 42);
        chk("wrap_tag1_b", int'(rob_retire_tag_1), 43);
        tick();

        // Fill to 32 entries, then drain
        for (int it = 0; it < 15; it++) begin
            disp(2); tick();
        end
        chk("fill_stall_30", int'(rob_stall), 0);
        disp(2); tick();
        chk("fill_stall_32", int'(rob_stall), 1);
        chk("fill_idx0", int'(rob_idx0), 2);
        disp(2); tick();
        chk("fill_drop2_idx0", int'(rob_idx0), 2);
        disp(1); tick();
        chk("fill_drop1_idx0", int'(rob_idx0), 2);
        chk("fill_stall_hold", int'(rob_stall), 1);
        for (int k = 0; k < 16; k++) begin
            c0((2 + 2 * k) % ROB_SIZE, 0); c1((3 + 2 * k) % ROB_SIZE, 0); tick();
        end
        tick(); tick();
        chk("drain_stall", int'(rob_stall), 0);
        chk("drain_num", int'(rob_retire_num), 0);

        // Mispredicted branch at idx 5, idx 6 already done
        disp(2); tick();
        disp(2); tick();
        disp(2); tick();
        c0(6, 0); tick();
        c0(2, 0); c1(3, 0); tick();
        chk("mis_num_23", int'(rob_retire_num), 2);
        c0(4, 0); tick();
        chk("mis_num_4", int'(rob_retire_num), 1);
        chk("mis_flush_4", int'(rob_flush), 0);
        c0(5, 1); tick();
        chk("mis_num_5", int'(rob_retire_num), 1);
        chk("mis_flush_5", int'(rob_flush), 1);
        chk("mis_tag0_5", int'(rob_retire_tag_0), 82);
        disp(2); c0(7, 0); tick();
        chk("post_flush_num", int'(rob_retire_num), 0);
        chk("post_flush_flush", int'(rob_flush), 0);
        chk("post_flush_idx0", int'(rob_idx0), 0);
        chk("post_flush_idx1", int'(rob_idx1), 1);
        chk("post_flush_stall", int'(rob_stall), 0);
        c0(7, 0); tick();
        chk("stale_cdb_num", int'(rob_retire_num), 0);

        // Asynchronous reset while two are retiring
        disp(2); tick();
        c0(0, 0); c1(1, 0); tick();
        chk("ar_num_before", int'(rob_retire_num), 2);
        chk("ar_idx0_before", int'(rob_idx0), 2);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_num", int'(rob_retire_num), 0);
        chk("ar_tag0", int'(rob_retire_tag_0), 0);
        chk("ar_tag1", int'(rob_retire_tag_1), 0);
        chk("ar_ar0", int'(rob_retire_ar0), 0);
        chk("ar_pr1", int'(rob_retire_pr1), 0);
        chk("ar_idx0", int'(rob_idx0), 0);
        chk("ar_idx1", int'(rob_idx1), 1);
        chk("ar_flush", int'(rob_flush), 0);
        chk("ar_stall", int'(rob_stall), 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        tick(); tick();
        chk("ar_after_num", int'(rob_retire_num), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
